// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a show-ahead byte FIFO with valid/ready pop.
// Flags framing errors (stop bit low) and overruns (byte completed while full) as one-cycle pulses.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CC_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CC_W-1:0] CC_HALF = CC_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CC_W-1:0] CC_FULL = CC_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

  state_t            state_q, state_d;
  logic [CC_W-1:0]   cc_q, cc_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_meta, rxs;
  logic              push_req, ferr_d;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              full, pop, push_ok;
  logic              frame_err_q, overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      state_q <= S_IDLE;
      cc_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      state_q <= state_d;
      cc_q    <= cc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cc_d     = cc_q + CC_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cc_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cc_q == CC_HALF) begin
          cc_d    = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cc_q == CC_FULL) begin
          cc_d    = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit gives half a bit of slack before the next start edge.
        if (cc_q == CC_FULL) begin
          cc_d = '0;
          if (rxs) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BRK;
          end
        end
      end
      S_BRK: begin
        cc_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid & rd_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      frame_err_q <= ferr_d;
      overrun_q   <= push_req & full & ~pop;
    end
  end

  assign rd_data    = mem[rd_ptr];
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and randomized frames against a queue-based FIFO/flag model.
module tb_uart_rx_fifo;

  localparam int CPB      = 217;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 3;
  localparam int FRAME    = 10 * CPB;
  // Edge (counted from the start-bit drive) on which the stop bit is sampled and the byte pushed.
  localparam int PUSH_OFS = 3 + CPB / 2 + 9 * CPB;

  logic             clk = 1'b0;
  logic             reset, rxd, rd_ready;
  logic [7:0]       rd_data;
  logic             rd_valid, frame_err, overrun, busy;
  logic [CNT_W-1:0] fifo_count;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .fifo_count(fifo_count), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int ferr_cnt = 0, ovr_cnt = 0, ferr_exp = 0, ovr_exp = 0;
  logic [7:0] model_q[$];
  logic v_before, v_after;
  logic [7:0] d_after;

  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (overrun === 1'b1)   ovr_cnt  <= ovr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd = 1'b1;
      rd_ready = 1'b0;
    end
  endtask

  // Drives one frame cycle by cycle; pop_at is the edge index on which rd_ready is high (-1: none).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at, input int ncyc);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == PUSH_OFS - 1) v_before = rd_valid;
      if (c == PUSH_OFS) begin
        v_after = rd_valid;
        d_after = rd_data;
      end
      rxd = bits[c / CPB];
      rd_ready = (c + 1 == pop_at);
      if (c + 1 == pop_at && model_q.size() > 0) begin
        chk("pop_head", rd_data, model_q[0]);
        void'(model_q.pop_front());
      end
      if (c + 1 == PUSH_OFS) begin
        if (!stop) ferr_exp++;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else ovr_exp++;
      end
    end
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    chk({tag, "_valid"}, rd_valid, 1);
    if (model_q.size() > 0) begin
      chk({tag, "_data"}, rd_data, model_q[0]);
      void'(model_q.pop_front());
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, fifo_count, model_q.size());
    chk({tag, "_valid"}, rd_valid, model_q.size() > 0);
    chk({tag, "_ferr"}, ferr_cnt, ferr_exp);
    chk({tag, "_ovr"}, ovr_cnt, ovr_exp);
  endtask

  initial begin
    logic [7:0] msg [5];
    msg = '{8'h34, 8'h35, 8'h2A, 8'h34, 8'h32};
    reset = 1'b1; rxd = 1'b1; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {frame_err, overrun}, 0);
    reset = 1'b0;

    idle(5000);
    chk("idle_busy", busy, 0);
    chk_state("idle");

    send_frame(8'h34, 1'b1, -1, FRAME);
    chk("lat_before", v_before, 0);
    chk("lat_after", v_after, 1);
    chk("lat_data", d_after, 8'h34);
    chk_state("one");
    pop_check("one_pop");
    chk("one_empty", rd_valid, 0);

    for (int i = 0; i < 5; i++) send_frame(msg[i], 1'b1, -1, FRAME);
    chk("ovr_one", ovr_cnt, 1);
    chk_state("full");
    for (int i = 0; i < 4; i++) pop_check("drain1");
    chk("drain1_empty", rd_valid, 0);

    for (int i = 0; i < 4; i++) send_frame(msg[i], 1'b1, -1, FRAME);
    send_frame(msg[4], 1'b1, PUSH_OFS, FRAME);
    chk("poppush_ovr", ovr_cnt, 1);
    chk_state("popush");
    for (int i = 0; i < 4; i++) pop_check("drain2");
    chk("drain2_empty", rd_valid, 0);

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rxd = 1'b0;
    end
    chk("glitch_busy", busy, 1);
    idle(300);
    chk("glitch_idle", busy, 0);
    chk_state("glitch");

    send_frame(8'h5A, 1'b0, -1, FRAME);
    for (int i = 0; i < 1000; i++) @(negedge clk);
    chk("brk_busy", busy, 1);
    chk("brk_ferr", ferr_cnt, 1);
    idle(5);
    chk("brk_idle", busy, 0);
    chk_state("brk");

    send_frame(8'h55, 1'b1, -1, FRAME);
    send_frame(8'h39, 1'b1, -1, 5 * CPB + 100);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", fifo_count, 0);
    model_q.delete();
    reset = 1'b0;
    idle(CPB);
    send_frame(8'h33, 1'b1, -1, FRAME);
    chk_state("after_rst");
    pop_check("after_rst_pop");

    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      int pa;
      b  = 8'($urandom_range(0, 255));
      pa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, FRAME - 1)) : -1;
      send_frame(b, $urandom_range(0, 7) != 0, pa, FRAME);
      idle(4 + int'($urandom_range(0, 150)));
      if ($urandom_range(0, 2) == 0) begin
        if (model_q.size() > 0) pop_check("rnd_pop");
        else begin
          rd_ready = 1'b1;
          @(negedge clk);
          rd_ready = 1'b0;
          chk("rnd_empty_pop", fifo_count, 0);
        end
      end
    end
    chk_state("rnd");
    while (model_q.size() > 0) pop_check("rnd_drain");
    chk("rnd_empty", rd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive front end feeding the SOC's memory-mapped UART data register.
- Deserialises 8N1 frames from the RXD pin and buffers the received bytes in a small show-ahead FIFO.
- The CPU drains the FIFO through a valid/ready pop interface.
- Flags framing errors and FIFO overruns so firmware can detect dropped operator/operand characters.

Parameters:
- CLKS_PER_BIT, 217, clocks per UART bit (25 MHz / 115200); must be >= 8.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 3, width of fifo_count; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial input; idles high.
- rd_data  output  8  byte at the FIFO head; valid only while rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- rd_ready  input  1  consumer pop request; a pop occurs when rd_valid & rd_ready.
- fifo_count  output  CNT_W  number of bytes currently stored.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while FIFO full; byte dropped.
- busy  output  1  receiver not in IDLE.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; bit counter and clock counter = 0.
  - FIFO pointers = 0; fifo_count=0; rd_valid=0.
  - frame_err=0, overrun=0, busy=0.
  - Synchroniser flops set to 1.
  - rd_data is don't-care.
  - Reset mid-frame abandons the frame; no partial byte is ever pushed.
- Input synchroniser: rxd passes through two flops to give rxs; all decisions use rxs (2-cycle input latency).
- State machine, with clock counter cc:
  - IDLE: rxs=0 -> START, cc=0.
  - START: at cc=CLKS_PER_BIT/2-1 (integer division), sample rxs. If 0 -> DATA, cc=0, bit=0. If 1 -> IDLE (glitch rejected; no flags raised).
  - DATA: at cc=CLKS_PER_BIT-1, sample rxs into shift register, LSB first; cc=0, bit+1. After bit 7 -> STOP.
  - STOP: at cc=CLKS_PER_BIT-1, sample rxs. If 1 -> push byte, go IDLE. If 0 -> pulse frame_err, drop byte, go BREAK.
  - BREAK: wait for rxs=1 -> IDLE. This prevents a held-low line from producing 0x00 bytes.
- Returning to IDLE at mid-stop-bit lets back-to-back frames be received with no gap.
- busy = (state != IDLE).
- FIFO:
  - Push occurs on the clk edge of the stop-bit sample.
  - rd_valid rises on the following cycle, with rd_data = the new byte if the FIFO was empty.
  - End-to-end latency: pin mid-stop-bit to rd_valid = 2 (sync) + 1 cycles.
  - Show-ahead: rd_data always presents the head entry while rd_valid=1.
  - Pop advances the read pointer; the next entry (or rd_valid=0) appears the following cycle.
  - Push and pop in the same cycle: both happen and fifo_count is unchanged. This holds when full: the pop frees space and the push is accepted, with no overrun.
  - Push when full with no pop: byte discarded, overrun pulses one cycle, contents unchanged.
  - Pop when empty: ignored; pointers and count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- frame_err and overrun are exactly one cycle wide and never assert in the same cycle as reset.

Test Plan:
- Reset, then hold rxd=1 for 5000 clocks -> rd_valid=0, busy=0, fifo_count=0, no flag pulses.
- Send 0x34 at 217 clocks/bit with rd_ready=0 -> rd_valid=1, rd_data=0x34, fifo_count=1 within 3 clocks of mid-stop-bit. Then rd_ready=1 for one cycle -> rd_valid=0 next cycle.
- Send "45*42" (0x34,0x35,0x2A,0x34,0x32) back-to-back with rd_ready=0 and FIFO_DEPTH=4:
  - First four bytes stored in order.
  - Fifth byte raises one overrun pulse; fifo_count=4.
  - Draining pops 0x34,0x35,0x2A,0x34.
- FIFO full, 5th byte completes in the same cycle as a pop -> no overrun; count stays 4; drain order 0x35,0x2A,0x34,0x32.
- Start-bit glitch: rxd low for 50 clocks, then high -> returns to IDLE, no push, no flags. Frame with stop bit forced 0 and line held low 1000 clocks -> one frame_err pulse, no push, busy stays 1 until rxd returns high.
- Assert reset at data bit 4 of 0x39, then send a clean 0x33 -> FIFO holds only 0x33, count=1.
